// File: rtl/credit_event_batcher.sv
// credit_event_batcher
//
// Upstream feeder for a 4-bit credit counter. Credit-return and credit-use
// bursts of up to MAX_IN credits per cycle are collected into two pending
// accumulators. At most 3 credits per direction per cycle are issued to the
// counter on registered incr/decr outputs. A software flush request is
// sequenced into a one-cycle reinit pulse that carries the configured initial
// value, followed by one quiet cycle.
//
// Optional build macro:
//   CREDIT_NET_CANCEL_EN - when defined, same-cycle returns and uses cancel
//   against each other before emission, and cancelled credits never reach the
//   counter. When undefined, the two directions are fully independent.
//
// Handshake: a burst on ret_* (use_*) is accepted in a cycle exactly when
// valid and ready are both high at the rising clock edge. Ready never depends
// on valid. The producer holds valid/num until accepted. A num of 0 is a legal
// burst that has no effect.
//
// Ports:
//   clk               rising-edge clock
//   rst_n             asynchronous active-low reset
//   i_ret_valid       credit-return burst valid
//   i_ret_num         credits returned in the burst
//   o_ret_ready       return burst may be accepted
//   i_use_valid       credit-use burst valid
//   i_use_num         credits consumed in the burst
//   o_use_ready       use burst may be accepted
//   i_flush_req       level request to reinitialise the counter
//   i_cfg_init        value to drive on o_initial_value during reinit
//   o_incr_valid      registered, incr is meaningful
//   o_incr            registered, credits to add (0..3)
//   o_decr_valid      registered, decr is meaningful
//   o_decr            registered, credits to remove (0..3)
//   o_reinit          registered one-cycle reinit pulse
//   o_initial_value   registered reinit value, holds outside reinit
//   o_pend_busy       combinational, either accumulator nonzero
//   o_dbg_state       current FSM state (RUN=0, FLUSH=1, SETTLE=2)

module credit_event_batcher #(
  parameter int IN_W   = 3,
  parameter int PEND_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_ret_valid,
  input  logic [IN_W-1:0]   i_ret_num,
  output logic              o_ret_ready,
  input  logic              i_use_valid,
  input  logic [IN_W-1:0]   i_use_num,
  output logic              o_use_ready,
  input  logic              i_flush_req,
  input  logic [3:0]        i_cfg_init,
  output logic              o_incr_valid,
  output logic [1:0]        o_incr,
  output logic              o_decr_valid,
  output logic [1:0]        o_decr,
  output logic              o_reinit,
  output logic [3:0]        o_initial_value,
  output logic              o_pend_busy,
  output logic [1:0]        o_dbg_state
);

  localparam int MAX_IN = (1 << IN_W) - 1;
  localparam int PMAX   = (1 << PEND_W) - 1;

  // Highest pending value that can still absorb a full burst: even after the
  // worst-case add, the same-cycle drain of 3 keeps the accumulator <= PMAX.
  localparam logic [PEND_W:0] RDY_LIM  = (PEND_W+1)'(PMAX + 3 - MAX_IN);
  localparam logic [PEND_W:0] EMIT_MAX = (PEND_W+1)'(3);

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_FLUSH  = 2'd1;
  localparam logic [1:0] ST_SETTLE = 2'd2;

  logic [1:0]        r_state;
  logic [PEND_W-1:0] r_inc_pend;
  logic [PEND_W-1:0] r_dec_pend;
  logic              r_incr_valid;
  logic [1:0]        r_incr;
  logic              r_decr_valid;
  logic [1:0]        r_decr;
  logic              r_reinit;
  logic [3:0]        r_initial_value;

  logic              w_run;
  logic              w_ret_ready;
  logic              w_use_ready;
  logic [PEND_W:0]   w_ret_acc;
  logic [PEND_W:0]   w_use_acc;
  logic [PEND_W:0]   w_inc_sum;
  logic [PEND_W:0]   w_dec_sum;
  logic [PEND_W:0]   w_inc_adj;
  logic [PEND_W:0]   w_dec_adj;
  logic [1:0]        w_inc_emit;
  logic [1:0]        w_dec_emit;
  logic [PEND_W-1:0] w_inc_left;
  logic [PEND_W-1:0] w_dec_left;

  assign w_run = (r_state == ST_RUN);

  // A flush request wins over handshakes in the same cycle, so readies drop
  // combinationally with it. rst_n gates ready so nothing is offered in reset.
  assign w_ret_ready = rst_n & w_run & ~i_flush_req & ({1'b0, r_inc_pend} <= RDY_LIM);
  assign w_use_ready = rst_n & w_run & ~i_flush_req & ({1'b0, r_dec_pend} <= RDY_LIM);

  assign w_ret_acc = (i_ret_valid & w_ret_ready) ? (PEND_W+1)'(i_ret_num) : '0;
  assign w_use_acc = (i_use_valid & w_use_ready) ? (PEND_W+1)'(i_use_num) : '0;

  assign w_inc_sum = {1'b0, r_inc_pend} + w_ret_acc;
  assign w_dec_sum = {1'b0, r_dec_pend} + w_use_acc;

`ifdef CREDIT_NET_CANCEL_EN
  // Credits returned and consumed in the same window cancel; only the
  // imbalance is ever presented to the counter.
  logic [PEND_W:0] w_net;
  assign w_net     = (w_inc_sum < w_dec_sum) ? w_inc_sum : w_dec_sum;
  assign w_inc_adj = w_inc_sum - w_net;
  assign w_dec_adj = w_dec_sum - w_net;
`else
  assign w_inc_adj = w_inc_sum;
  assign w_dec_adj = w_dec_sum;
`endif

  assign w_inc_emit = (w_inc_adj > EMIT_MAX) ? 2'd3 : w_inc_adj[1:0];
  assign w_dec_emit = (w_dec_adj > EMIT_MAX) ? 2'd3 : w_dec_adj[1:0];

  // The true remainder always fits in PEND_W bits (readiness guarantees it),
  // so the subtraction is done at accumulator width.
  assign w_inc_left = w_inc_adj[PEND_W-1:0] - PEND_W'(w_inc_emit);
  assign w_dec_left = w_dec_adj[PEND_W-1:0] - PEND_W'(w_dec_emit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= ST_RUN;
      r_inc_pend      <= '0;
      r_dec_pend      <= '0;
      r_incr_valid    <= 1'b0;
      r_incr          <= 2'd0;
      r_decr_valid    <= 1'b0;
      r_decr          <= 2'd0;
      r_reinit        <= 1'b0;
      r_initial_value <= 4'd0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (i_flush_req) begin
            // Pending credits are discarded: the counter is about to be
            // overwritten with cfg_init anyway.
            r_state         <= ST_FLUSH;
            r_inc_pend      <= '0;
            r_dec_pend      <= '0;
            r_incr_valid    <= 1'b0;
            r_incr          <= 2'd0;
            r_decr_valid    <= 1'b0;
            r_decr          <= 2'd0;
            r_reinit        <= 1'b1;
            r_initial_value <= i_cfg_init;
          end else begin
            r_inc_pend   <= w_inc_left;
            r_dec_pend   <= w_dec_left;
            r_incr_valid <= (w_inc_emit != 2'd0);
            r_incr       <= w_inc_emit;
            r_decr_valid <= (w_dec_emit != 2'd0);
            r_decr       <= w_dec_emit;
            r_reinit     <= 1'b0;
          end
        end
        ST_FLUSH: begin
          r_state      <= ST_SETTLE;
          r_inc_pend   <= '0;
          r_dec_pend   <= '0;
          r_incr_valid <= 1'b0;
          r_incr       <= 2'd0;
          r_decr_valid <= 1'b0;
          r_decr       <= 2'd0;
          r_reinit     <= 1'b0;
        end
        default: begin
          // SETTLE (and any unreachable encoding) returns to RUN quietly.
          r_state      <= ST_RUN;
          r_inc_pend   <= '0;
          r_dec_pend   <= '0;
          r_incr_valid <= 1'b0;
          r_incr       <= 2'd0;
          r_decr_valid <= 1'b0;
          r_decr       <= 2'd0;
          r_reinit     <= 1'b0;
        end
      endcase
    end
  end

  assign o_ret_ready     = w_ret_ready;
  assign o_use_ready     = w_use_ready;
  assign o_incr_valid    = r_incr_valid;
  assign o_incr          = r_incr;
  assign o_decr_valid    = r_decr_valid;
  assign o_decr          = r_decr;
  assign o_reinit        = r_reinit;
  assign o_initial_value = r_initial_value;
  assign o_pend_busy     = (|r_inc_pend) | (|r_dec_pend);
  assign o_dbg_state     = r_state;

endmodule

// File: tb/tb_credit_event_batcher.sv
module tb_credit_event_batcher;

  localparam int IN_W    = 3;
  localparam int PEND_W  = 5;
  localparam int RDY_LIM = ((1 << PEND_W) - 1) + 3 - ((1 << IN_W) - 1);

  logic            clk;
  logic            rst_n;
  logic            ret_valid;
  logic [IN_W-1:0] ret_num;
  logic            ret_ready;
  logic            use_valid;
  logic [IN_W-1:0] use_num;
  logic            use_ready;
  logic            flush_req;
  logic [3:0]      cfg_init;
  logic            incr_valid;
  logic [1:0]      incr;
  logic            decr_valid;
  logic [1:0]      decr;
  logic            reinit;
  logic [3:0]      initial_value;
  logic            pend_busy;
  logic [1:0]      dbg_state;

  credit_event_batcher #(.IN_W(IN_W), .PEND_W(PEND_W)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_ret_valid     (ret_valid),
    .i_ret_num       (ret_num),
    .o_ret_ready     (ret_ready),
    .i_use_valid     (use_valid),
    .i_use_num       (use_num),
    .o_use_ready     (use_ready),
    .i_flush_req     (flush_req),
    .i_cfg_init      (cfg_init),
    .o_incr_valid    (incr_valid),
    .o_incr          (incr),
    .o_decr_valid    (decr_valid),
    .o_decr          (decr),
    .o_reinit        (reinit),
    .o_initial_value (initial_value),
    .o_pend_busy     (pend_busy),
    .o_dbg_state     (dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- check bookkeeping ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Credits are tracked as plain counts per direction. After a flush the
  // block is unavailable for a fixed number of cycles (pulse + quiet).
  int m_ip, m_dp;
  int m_blocked;
  int m_ra, m_ua, m_ts, m_us, m_c;
  int e_incr, e_decr, e_init;
  bit e_iv, e_dv, e_reinit;
  int tot_ret_acc = 0;
  int tot_incr    = 0;

  function automatic int min_int(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic bit m_ready(input int p);
    return rst_n && (m_blocked == 0) && !flush_req && (p <= RDY_LIM);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ip = 0; m_dp = 0; m_blocked = 0;
      e_incr = 0; e_decr = 0; e_iv = 0; e_dv = 0; e_reinit = 0; e_init = 0;
    end else if (m_blocked > 0) begin
      m_blocked--;
      e_incr = 0; e_decr = 0; e_iv = 0; e_dv = 0; e_reinit = 0;
    end else if (flush_req) begin
      m_blocked = 2;
      m_ip = 0; m_dp = 0;
      e_incr = 0; e_decr = 0; e_iv = 0; e_dv = 0;
      e_reinit = 1; e_init = cfg_init;
    end else begin
      m_ra = (ret_valid && m_ip <= RDY_LIM) ? int'(ret_num) : 0;
      m_ua = (use_valid && m_dp <= RDY_LIM) ? int'(use_num) : 0;
      tot_ret_acc += m_ra;
      m_ts = m_ip + m_ra;
      m_us = m_dp + m_ua;
`ifdef CREDIT_NET_CANCEL_EN
      m_c  = min_int(m_ts, m_us);
      m_ts = m_ts - m_c;
      m_us = m_us - m_c;
`endif
      e_incr = min_int(m_ts, 3);
      e_decr = min_int(m_us, 3);
      e_iv   = (e_incr != 0);
      e_dv   = (e_decr != 0);
      m_ip   = m_ts - e_incr;
      m_dp   = m_us - e_decr;
      e_reinit = 0;
      if (m_ip > (1 << PEND_W) - 1 || m_dp > (1 << PEND_W) - 1) begin
        checks++; errors++;
        $display("FAIL model_overflow: ip %0d dp %0d", m_ip, m_dp);
      end
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    check("incr_valid", 32'(incr_valid), 32'(e_iv));
    check("incr", 32'(incr), e_incr);
    check("decr_valid", 32'(decr_valid), 32'(e_dv));
    check("decr", 32'(decr), e_decr);
    check("reinit", 32'(reinit), 32'(e_reinit));
    check("initial_value", 32'(initial_value), e_init);
    check("ret_ready", 32'(ret_ready), 32'(m_ready(m_ip)));
    check("use_ready", 32'(use_ready), 32'(m_ready(m_dp)));
    check("pend_busy", 32'(pend_busy), 32'((m_ip != 0) || (m_dp != 0)));
    if (rst_n && incr_valid) tot_incr += int'(incr);
  end

  // ---------------- driver ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ret_valid = 0; ret_num = 0; use_valid = 0; use_num = 0; flush_req = 0;
  endtask

  logic [IN_W-1:0] tab_rn [8] = '{3'd6, 3'd0, 3'd1, 3'd4, 3'd7, 3'd2, 3'd0, 3'd5};
  logic [IN_W-1:0] tab_un [8] = '{3'd0, 3'd6, 3'd3, 3'd4, 3'd1, 3'd7, 3'd2, 3'd0};
  bit              tab_rv [8] = '{1, 0, 1, 1, 1, 1, 0, 1};
  bit              tab_uv [8] = '{0, 1, 1, 1, 0, 1, 1, 1};

  initial begin
    int a0, i0, n_acc;
    bit rdy [10];
    bit drained;

    rst_n = 0; cfg_init = 4'h0;
    idle_inputs();

    // reset values
    repeat (3) step();
    check("rst_incr_valid", 32'(incr_valid), 0);
    check("rst_reinit", 32'(reinit), 0);
    check("rst_ret_ready", 32'(ret_ready), 0);
    check("rst_use_ready", 32'(use_ready), 0);
    rst_n = 1;
    #1;
    check("run_ret_ready", 32'(ret_ready), 1);
    check("run_use_ready", 32'(use_ready), 1);
    check("run_pend_busy", 32'(pend_busy), 0);
    check("run_state", 32'(dbg_state), 0);

    // single burst of 7 drains as 3,3,1
    ret_valid = 1; ret_num = 3'd7;
    step();
    ret_valid = 0;
    check("burst_v0", 32'(incr_valid), 1);
    check("burst_n0", 32'(incr), 3);
    step();
    check("burst_n1", 32'(incr), 3);
    step();
    check("burst_n2", 32'(incr), 1);
    step();
    check("burst_v3", 32'(incr_valid), 0);
    check("burst_busy", 32'(pend_busy), 0);

    // backpressure with back-to-back full bursts
    a0 = tot_ret_acc; i0 = tot_incr; n_acc = 0;
    ret_valid = 1; ret_num = 3'd7;
    for (int i = 0; i < 10; i++) begin
      #1;
      rdy[i] = ret_ready;
      if (ret_ready) n_acc++;
      step();
    end
    ret_valid = 0;
    check("bp_ready6", 32'(rdy[6]), 1);
    check("bp_ready7", 32'(rdy[7]), 0);
    check("bp_ready8", 32'(rdy[8]), 1);
    check("bp_ready9", 32'(rdy[9]), 0);
    check("bp_accepts", n_acc, 8);
    drained = 0;
    for (int i = 0; i < 20 && !drained; i++) begin
      step();
      drained = !pend_busy;
    end
    check("bp_drain_timeout", 32'(drained), 1);
    repeat (2) step();
    check("bp_conserve", tot_incr - i0, tot_ret_acc - a0);
    check("bp_total", tot_incr - i0, 56);

    // simultaneous return 2 and use 5
    ret_valid = 1; ret_num = 3'd2; use_valid = 1; use_num = 3'd5;
    step();
    idle_inputs();
`ifdef CREDIT_NET_CANCEL_EN
    check("sim_iv", 32'(incr_valid), 0);
    check("sim_dv", 32'(decr_valid), 1);
    check("sim_decr", 32'(decr), 3);
    step();
    check("sim_dv2", 32'(decr_valid), 0);
    ret_valid = 1; ret_num = 3'd2; use_valid = 1; use_num = 3'd2;
    step();
    idle_inputs();
    check("cancel_iv", 32'(incr_valid), 0);
    check("cancel_dv", 32'(decr_valid), 0);
`else
    check("sim_iv", 32'(incr_valid), 1);
    check("sim_incr", 32'(incr), 2);
    check("sim_dv", 32'(decr_valid), 1);
    check("sim_decr", 32'(decr), 3);
    step();
    check("sim_iv2", 32'(incr_valid), 0);
    check("sim_decr2", 32'(decr), 2);
    step();
    check("sim_dv3", 32'(decr_valid), 0);
`endif

    // mixed traffic table, checked by the compare process
    for (int i = 0; i < 8; i++) begin
      ret_valid = tab_rv[i]; ret_num = tab_rn[i];
      use_valid = tab_uv[i]; use_num = tab_un[i];
      step();
    end
    idle_inputs();
    repeat (8) step();

    // flush with inc_pend = 10
    ret_valid = 1; ret_num = 3'd7;
    step();
    step();
    ret_num = 3'd5;
    step();
    ret_num = 3'd7; flush_req = 1; cfg_init = 4'h9;
    #1;
    check("fl_ret_ready", 32'(ret_ready), 0);
    check("fl_use_ready", 32'(use_ready), 0);
    step();
    idle_inputs();
    check("fl_reinit", 32'(reinit), 1);
    check("fl_init", 32'(initial_value), 9);
    check("fl_iv", 32'(incr_valid), 0);
    check("fl_state", 32'(dbg_state), 1);
    check("fl_busy", 32'(pend_busy), 0);
    step();
    check("settle_reinit", 32'(reinit), 0);
    check("settle_state", 32'(dbg_state), 2);
    check("settle_ready", 32'(ret_ready), 0);
    step();
    check("post_state", 32'(dbg_state), 0);
    check("post_ready", 32'(ret_ready), 1);
    check("post_init_hold", 32'(initial_value), 9);

    // async reset while in FLUSH
    flush_req = 1; cfg_init = 4'h5;
    step();
    flush_req = 0;
    check("ar_reinit", 32'(reinit), 1);
    check("ar_init", 32'(initial_value), 5);
    #2 rst_n = 0;
    #1;
    check("ar_reinit_drop", 32'(reinit), 0);
    check("ar_state", 32'(dbg_state), 0);
    #3 rst_n = 1;
    #1;
    check("ar_post_ready", 32'(use_ready), 1);
    check("ar_post_busy", 32'(pend_busy), 0);
    repeat (3) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
